// File: rtl/spram_access.sv
// Byte/halfword/word load-store front end for a 64 KB single-port 32-bit SPRAM.
// Splits word-straddling accesses into two back-to-back SPRAM cycles and merges reads.
module spram_access (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  sz,
    input  logic        sx,
    input  logic [15:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        m_we,
    output logic [3:0]  m_bmsk,
    output logic [15:0] m_a,
    output logic [31:0] m_vi,
    input  logic [31:0] m_vo
);

    typedef enum logic [1:0] {
        IDLE,
        SPLIT,
        DONE
    } state_t;

    state_t state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  sz_q, sz_d;
    logic        sx_q, sx_d;
    logic [1:0]  off_q, off_d;
    logic [13:0] w_q, w_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] hold_q, hold_d;

    logic [1:0]  c_sz;
    logic [1:0]  c_off;
    logic [7:0]  nmask;
    logic [7:0]  lmask;
    logic        split_c;
    logic [63:0] rd64;
    logic [31:0] rsh;

    // In IDLE the lane mask comes from the live request, afterwards from the latched one.
    always_comb begin
        c_sz  = (state_q == IDLE) ? sz : sz_q;
        c_off = (state_q == IDLE) ? addr[1:0] : off_q;
        unique case (c_sz)
            2'd0:    nmask = 8'h01;
            2'd1:    nmask = 8'h03;
            default: nmask = 8'h0F;
        endcase
        lmask   = nmask << c_off;
        split_c = |lmask[7:4];
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        sz_d    = sz_q;
        sx_d    = sx_q;
        off_d   = off_q;
        w_d     = w_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        ready   = 1'b0;
        ack     = 1'b0;
        rdata   = 32'd0;
        m_we    = 1'b0;
        m_bmsk  = 4'd0;
        m_a     = 16'd0;
        m_vi    = 32'd0;
        rd64    = 64'd0;
        rsh     = 32'd0;
        unique case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (req) begin
                    m_a     = {2'b00, addr[15:2]};
                    m_bmsk  = we ? lmask[3:0] : 4'd0;
                    m_we    = we;
                    m_vi    = wdata << {addr[1:0], 3'b000};
                    we_d    = we;
                    sz_d    = sz;
                    sx_d    = sx;
                    off_d   = addr[1:0];
                    w_d     = addr[15:2];
                    wdata_d = wdata;
                    state_d = split_c ? SPLIT : DONE;
                end
            end
            SPLIT: begin
                m_a     = {2'b00, w_q + 14'd1};
                m_bmsk  = we_q ? lmask[7:4] : 4'd0;
                m_we    = we_q;
                m_vi    = wdata_q >> (6'd32 - {1'b0, off_q, 3'b000});
                hold_d  = m_vo;
                state_d = DONE;
            end
            DONE: begin
                ack     = 1'b1;
                rd64    = split_c ? {m_vo, hold_q} : {32'd0, m_vo};
                rsh     = 32'(rd64 >> {off_q, 3'b000});
                if (!we_q) begin
                    unique case (sz_q)
                        2'd0:    rdata = {{24{sx_q & rsh[7]}}, rsh[7:0]};
                        2'd1:    rdata = {{16{sx_q & rsh[15]}}, rsh[15:0]};
                        default: rdata = rsh;
                    endcase
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            sz_q    <= 2'd0;
            sx_q    <= 1'b0;
            off_q   <= 2'd0;
            w_q     <= 14'd0;
            wdata_q <= 32'd0;
            hold_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            sz_q    <= sz_d;
            sx_q    <= sx_d;
            off_q   <= off_d;
            w_q     <= w_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_spram_access.sv
// Directed bench for spram_access with an SPRAM model and a byte-level reference memory.
// Expected read data is queued at issue time and compared on ack.
module tb_spram_access;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [1:0]  sz;
    logic        sx;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        ack;
    logic [31:0] rdata;
    logic        m_we;
    logic [3:0]  m_bmsk;
    logic [15:0] m_a;
    logic [31:0] m_vi;
    logic [31:0] m_vo;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem [0:16383];
    logic [7:0]  ref_mem [0:65535];
    logic [31:0] sb [$];

    always #5 clk = ~clk;

    spram_access dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .we     (we),
        .sz     (sz),
        .sx     (sx),
        .addr   (addr),
        .wdata  (wdata),
        .ready  (ready),
        .ack    (ack),
        .rdata  (rdata),
        .m_we   (m_we),
        .m_bmsk (m_bmsk),
        .m_a    (m_a),
        .m_vi   (m_vi),
        .m_vo   (m_vo)
    );

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (m_we && m_bmsk[i])
                mem[m_a[13:0]][8*i +: 8] <= m_vi[8*i +: 8];
        m_vo <= mem[m_a[13:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] vmask(input logic [3:0] b);
        logic [31:0] m;
        for (int i = 0; i < 4; i++)
            m[8*i +: 8] = b[i] ? 8'hFF : 8'h00;
        return m;
    endfunction

    task automatic access(input logic w_e, input logic [1:0] s,
                          input logic x, input logic [15:0] a,
                          input logic [31:0] wd);
        int n;
        int lat;
        logic [3:0]  bm1, bm2;
        logic [31:0] vi1, vi2, er;
        logic [13:0] w0;
        logic [15:0] ab;
        logic        split;
        n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        w0 = a[15:2];
        bm1 = '0; bm2 = '0; vi1 = '0; vi2 = '0; er = '0; split = 1'b0;
        for (int k = 0; k < n; k++) begin
            ab = a + 16'(k);
            if (ab[15:2] == w0) begin
                bm1[ab[1:0]] = 1'b1;
                vi1[8*ab[1:0] +: 8] = wd[8*k +: 8];
            end else begin
                bm2[ab[1:0]] = 1'b1;
                vi2[8*ab[1:0] +: 8] = wd[8*k +: 8];
                split = 1'b1;
            end
            if (w_e) ref_mem[ab] = wd[8*k +: 8];
            else     er[8*k +: 8] = ref_mem[ab];
        end
        if (!w_e && x && n == 1 && er[7])  er = er | 32'hFFFFFF00;
        if (!w_e && x && n == 2 && er[15]) er = er | 32'hFFFF0000;

        @(posedge clk); #1;
        chk("ready_idle", {31'd0, ready}, 32'd1);
        req = 1'b1; we = w_e; sz = s; sx = x; addr = a; wdata = wd;
        #1;
        chk("a1_m_a", {16'd0, m_a}, {18'd0, w0});
        chk("a1_m_bmsk", {28'd0, m_bmsk}, {28'd0, w_e ? bm1 : 4'd0});
        chk("a1_m_we", {31'd0, m_we}, {31'd0, w_e});
        chk("a1_m_vi", m_vi & vmask(bm1), vi1);
        sb.push_back(er);

        @(posedge clk); #1;
        req = 1'b0; we = 1'b0; sz = '0; sx = 1'b0; addr = '0; wdata = '0;
        lat = 1;
        if (split) begin
            chk("a2_m_a", {16'd0, m_a}, {18'd0, w0 + 14'd1});
            chk("a2_m_bmsk", {28'd0, m_bmsk}, {28'd0, w_e ? bm2 : 4'd0});
            chk("a2_m_we", {31'd0, m_we}, {31'd0, w_e});
            chk("a2_m_vi", m_vi & vmask(bm2), vi2);
            chk("a2_no_ack", {31'd0, ack}, 32'd0);
        end
        while (!ack && lat < 4) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("ack_latency", 32'(lat), split ? 32'd2 : 32'd1);
        if (sb.size() > 0) er = sb.pop_front();
        if (ack) begin
            chk("rdata", rdata, er);
            chk("done_m_we", {31'd0, m_we}, 32'd0);
        end
        @(posedge clk); #1;
        chk("ready_after", {31'd0, ready}, 32'd1);
        chk("ack_after", {31'd0, ack}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = '0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = '0;
        m_vo = '0;
        rst_n = 1'b0;
        req = 1'b0; we = 1'b0; sz = '0; sx = 1'b0; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_m_we", {31'd0, m_we}, 32'd0);
        chk("rst_m_bmsk", {28'd0, m_bmsk}, 32'd0);

        access(1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEADBEEF);
        access(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0);
        access(1'b1, 2'd0, 1'b0, 16'h0013, 32'h00000080);
        access(1'b0, 2'd0, 1'b1, 16'h0013, 32'h0);
        access(1'b0, 2'd0, 1'b0, 16'h0013, 32'h0);
        access(1'b1, 2'd1, 1'b0, 16'h0021, 32'h00001234);
        access(1'b0, 2'd1, 1'b1, 16'h0021, 32'h0);
        access(1'b1, 2'd2, 1'b0, 16'h0103, 32'hAABBCCDD);
        access(1'b0, 2'd2, 1'b0, 16'h0103, 32'h0);
        access(1'b0, 2'd3, 1'b0, 16'h0103, 32'h0);
        access(1'b0, 2'd1, 1'b1, 16'h0103, 32'h0);
        access(1'b0, 2'd1, 1'b0, 16'h0103, 32'h0);
        access(1'b1, 2'd2, 1'b0, 16'hFFFE, 32'h11223344);
        access(1'b0, 2'd2, 1'b0, 16'hFFFE, 32'h0);
        access(1'b1, 2'd1, 1'b0, 16'h0043, 32'h0000A5F0);
        access(1'b0, 2'd1, 1'b1, 16'h0043, 32'h0);

        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; sz = 2'd2; addr = 16'h0103;
        @(posedge clk); #1;
        req = 1'b0; addr = '0; sz = '0;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", {31'd0, ready}, 32'd1);
        chk("midrst_m_we", {31'd0, m_we}, 32'd0);
        chk("midrst_ack", {31'd0, ack}, 32'd0);
        chk("midrst_m_bmsk", {28'd0, m_bmsk}, 32'd0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("midrst_no_ack", {31'd0, ack}, 32'd0);
        end
        access(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
